sigmoid_tanh_pipe: RTL
======================

SIGMOID_TANH_PIPE -- requirements
Module: sigmoid_tanh_pipe

Interface
REQ-001 SHALL provide parameter W, default 16, meaning total data width in bits (signed two's complement, fixed point).
REQ-002 SHALL provide parameter FW, default 8, meaning fractional bits; legal range 2 <= FW <= W-2, otherwise elaboration error.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  input sample present.
REQ-006 SHALL provide port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL provide port in_data  input  W  operand x, signed Q(W-FW).FW.
REQ-008 SHALL provide port in_mode  input  1  0 = sigmoid, 1 = tanh; sampled with in_data.
REQ-009 SHALL provide port out_valid  output  1  result present.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts result.
REQ-011 SHALL provide port out_data  output  W  result, same Q format as in_data.
REQ-012 SHALL provide port out_sat  output  1  result saturated (shift clamped or |x| clamped), qualified by out_valid.

Function
REQ-013 Transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
REQ-014 Three-stage pipeline; accepted sample appears at out_valid exactly 3 cycles later when no stall.
REQ-015 stall = out_valid & ~out_ready; during stall all stages hold, in_ready = 0; otherwise in_ready = 1 (pipeline advances every cycle, bubbles allowed).
REQ-016 out_data/out_sat SHALL remain stable while out_valid & ~out_ready.
REQ-017 Stage 1: tanh mode operand z = 2x saturated to [-2^(W-1), 2^(W-1)-1]; sigmoid mode z = x; neg = z[W-1]; a = |z|, with |−2^(W-1)| clamped to 2^(W-1)-1; sat flag set on either clamp.
REQ-018 Stage 2: n = a[W-1:FW] (unsigned integer part), f = a[FW-1:0]; g = 2^(FW-1) - (f >> 2); h = g >> n, with h = 0 and sat flag set when n > FW.
REQ-019 Stage 3: s = neg ? h : 2^FW - h (sigmoid of z, truncation, no rounding); sigmoid mode out_data = s; tanh mode out_data = 2s - 2^FW, signed.
REQ-020 All intermediate arithmetic SHALL be W bits wide minimum; no intermediate overflow for any input.
REQ-021 Mode and sat flag SHALL travel with their sample through every stage; mixed-mode back-to-back samples SHALL not interfere.
REQ-022 Simultaneous output transfer and input acceptance in the same cycle SHALL lose no sample.

Reset
REQ-023 rst high at a clock edge SHALL clear all stage valid bits; out_valid = 0, out_sat = 0, out_data = 0 the following cycle.
REQ-024 Reset mid-operation SHALL discard all in-flight samples; in_ready = 0 while rst is high, 1 the cycle after rst deasserts.
REQ-025 No sample accepted in the reset cycle SHALL ever appear at the output.

Verification (W=16, FW=8)
REQ-026 Sigmoid points, out_ready=1: x=0x0000 -> 0x0080; 0x0080 -> 0x00A0; 0x0100 -> 0x00C0; 0xFF00 -> 0x0040; each 3 cycles after acceptance, out_sat=0.
REQ-027 Saturation: sigmoid x=0x0A00 -> 0x0100, out_sat=1; x=0x8000 -> 0x0000, out_sat=1.
REQ-028 Tanh points: x=0x0000 -> 0x0000; 0x0080 -> 0x0080; 0xFF80 -> 0xFF80; x=0x4000 -> 0x0100 with out_sat=1.
REQ-029 Backpressure: stream of 8 alternating-mode samples, out_ready toggled randomly; outputs in order, matching golden model, held stable during stall, none lost or duplicated.
REQ-030 Reset mid-stream: 2 samples in flight, rst pulsed 1 cycle -> out_valid=0 next cycle, neither sample emitted, next accepted sample emitted after 3 cycles.

Source files
------------

// File: rtl/sigmoid_tanh_pipe.sv
// Three-stage piecewise-linear sigmoid/tanh on signed fixed-point samples.
// tanh(x) is derived as 2*sigmoid(2x) - 1; the whole pipeline freezes while the output is stalled.
module sigmoid_tanh_pipe #(
    parameter int W  = 16,
    parameter int FW = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    generate
        if (FW < 2 || FW > W - 2) begin : g_bad_fw
            $error("sigmoid_tanh_pipe: FW must satisfy 2 <= FW <= W-2");
        end
    endgenerate

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = W'(1) << FW;
    localparam logic [W-1:0] HALF = W'(1) << (FW - 1);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~stall;

    // stage 1 registers
    logic         v1, mode1, neg1, sat1;
    logic [W-1:0] a1;
    // stage 2 registers
    logic         v2, mode2, neg2, sat2;
    logic [W-1:0] h2;

    // stage 1: operand doubling for tanh and magnitude, both saturating
    logic [W-1:0] z, a;
    logic         neg, clamp;
    always_comb begin
        z     = in_data;
        clamp = 1'b0;
        if (in_mode) begin
            if (in_data[W-1] != in_data[W-2]) begin
                z     = in_data[W-1] ? SMIN : SMAX;
                clamp = 1'b1;
            end else begin
                z = {in_data[W-2:0], 1'b0};
            end
        end
        neg = z[W-1];
        if (z == SMIN) begin
            a     = SMAX;
            clamp = 1'b1;
        end else begin
            a = neg ? (~z) + W'(1) : z;
        end
    end

    // stage 2: segment slope by integer part, shift clamped beyond FW
    logic [W-FW-1:0] n;
    logic [FW-1:0]   f;
    logic [W-1:0]    g, h;
    logic            big;
    always_comb begin
        n   = a1[W-1:FW];
        f   = a1[FW-1:0];
        g   = HALF - W'(f >> 2);
        big = W'(n) > W'(FW);
        h   = big ? '0 : (g >> n);
    end

    // stage 3: mirror for positive operands, rescale for tanh in W+1 bits
    logic [W-1:0] s, res;
    logic [W:0]   t;
    always_comb begin
        s   = neg2 ? h2 : ONE - h2;
        t   = {s, 1'b0} - {1'b0, ONE};
        res = mode2 ? t[W-1:0] : s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            mode1     <= 1'b0;
            neg1      <= 1'b0;
            sat1      <= 1'b0;
            a1        <= '0;
            mode2     <= 1'b0;
            neg2      <= 1'b0;
            sat2      <= 1'b0;
            h2        <= '0;
        end else if (!stall) begin
            v1        <= in_valid;
            mode1     <= in_mode;
            neg1      <= neg;
            sat1      <= clamp;
            a1        <= a;
            v2        <= v1;
            mode2     <= mode1;
            neg2      <= neg1;
            sat2      <= sat1 | big;
            h2        <= h;
            out_valid <= v2;
            out_data  <= res;
            out_sat   <= sat2;
        end
    end

endmodule
